// File: rtl/bpu_predictor_if.sv
// Fetch-side lookup and execute-side update bus of the branch predictor.
interface bpu_predictor_if;
    // fetch lookup
    logic        req_i;
    logic [29:0] pc_i;
    logic        pred_valid_o;
    logic [29:0] npc_o;
    logic        pred_taken_o;
    // resolved-branch feedback
    logic        upd_flush_i;
    logic        upd_btb_update_i;
    logic        upd_bht_update_i;
    logic [29:0] upd_pc_i;
    logic [29:0] upd_target_i;
    logic        upd_taken_i;
    logic [1:0]  upd_br_type_i;

    modport master (
        output req_i, pc_i, upd_flush_i, upd_btb_update_i, upd_bht_update_i,
               upd_pc_i, upd_target_i, upd_taken_i, upd_br_type_i,
        input  pred_valid_o, npc_o, pred_taken_o
    );

    modport slave (
        input  req_i, pc_i, upd_flush_i, upd_btb_update_i, upd_bht_update_i,
               upd_pc_i, upd_target_i, upd_taken_i, upd_br_type_i,
        output pred_valid_o, npc_o, pred_taken_o
    );
endinterface

// File: rtl/bpu_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and a commit-side return
// address stack. One lookup per cycle, registered one-cycle result.
module bpu_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int RAS_DEPTH   = 8
) (
    input logic            clk,
    input logic            rst_n,
    bpu_predictor_if.slave bus
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = 30 - IDX;
    localparam int RP  = $clog2(RAS_DEPTH);

    localparam logic [1:0] BR_PCREL  = 2'd0;
    localparam logic [1:0] BR_ABS    = 2'd1;
    localparam logic [1:0] BR_CALL   = 2'd2;
    localparam logic [1:0] BR_RETURN = 2'd3;

    // BTB storage
    logic [BTB_ENTRIES-1:0] vld_q;
    logic [TW-1:0]          tag_q [BTB_ENTRIES];
    logic [29:0]            tgt_q [BTB_ENTRIES];
    logic [1:0]             typ_q [BTB_ENTRIES];
    logic [1:0]             cnt_q [BTB_ENTRIES];

    // RAS: circular buffer, sp points at the next free slot
    logic [29:0]            ras_q [RAS_DEPTH];
    logic [RP-1:0]          ras_sp_q;
    logic [RP:0]            ras_cnt_q;

    // registered lookup outputs
    logic                   pred_valid_q;
    logic [29:0]            npc_q;
    logic                   taken_q;

    // ---------------- lookup (reads start-of-cycle state) ----------------
    logic [IDX-1:0] l_idx;
    logic           l_hit;
    logic [RP-1:0]  ras_top_idx;
    logic           ras_empty;
    logic [29:0]    npc_d;
    logic           taken_d;

    assign l_idx       = bus.pc_i[IDX-1:0];
    assign l_hit       = vld_q[l_idx] && (tag_q[l_idx] == bus.pc_i[29:IDX]);
    assign ras_top_idx = ras_sp_q - 1'b1;
    assign ras_empty   = (ras_cnt_q == '0);

    // Next-PC selection; a RETURN with an empty RAS falls through to pc+1
    always_comb begin
        npc_d   = bus.pc_i + 30'd1;
        taken_d = 1'b0;
        if (l_hit) begin
            unique case (typ_q[l_idx])
                BR_RETURN: if (!ras_empty) begin
                    npc_d   = ras_q[ras_top_idx];
                    taken_d = 1'b1;
                end
                BR_ABS, BR_CALL: begin
                    npc_d   = tgt_q[l_idx];
                    taken_d = 1'b1;
                end
                default: if (cnt_q[l_idx][1]) begin
                    npc_d   = tgt_q[l_idx];
                    taken_d = 1'b1;
                end
            endcase
        end
    end

    // Output register; npc/taken hold when no request, valid is killed by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q <= 1'b0;
            npc_q        <= '0;
            taken_q      <= 1'b0;
        end else begin
            pred_valid_q <= bus.req_i & ~bus.upd_flush_i;
            if (bus.req_i) begin
                npc_q   <= npc_d;
                taken_q <= taken_d;
            end
        end
    end

    assign bus.pred_valid_o = pred_valid_q;
    assign bus.npc_o        = npc_q;
    assign bus.pred_taken_o = taken_q;

    // ---------------- update ----------------
    logic [IDX-1:0] u_idx;
    logic           u_hit;
    logic           u_write;
    logic           u_alloc;
    logic           u_train;
    logic [1:0]     cnt_d;

    assign u_idx   = bus.upd_pc_i[IDX-1:0];
    assign u_hit   = vld_q[u_idx] && (tag_q[u_idx] == bus.upd_pc_i[29:IDX]);
    assign u_write = bus.upd_btb_update_i & bus.upd_taken_i;
    assign u_alloc = u_write & ~u_hit;
    assign u_train = bus.upd_bht_update_i & u_hit;

    // Saturating counter step for the entry being trained
    always_comb begin
        cnt_d = cnt_q[u_idx];
        if (bus.upd_taken_i) begin
            if (cnt_q[u_idx] != 2'd3) cnt_d = cnt_q[u_idx] + 2'd1;
        end else begin
            if (cnt_q[u_idx] != 2'd0) cnt_d = cnt_q[u_idx] - 2'd1;
        end
    end

    // BTB write/allocate and counter training; allocation value wins over training
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                typ_q[i] <= BR_PCREL;
                cnt_q[i] <= 2'b01;
            end
        end else begin
            if (u_write) begin
                vld_q[u_idx] <= 1'b1;
                tag_q[u_idx] <= bus.upd_pc_i[29:IDX];
                tgt_q[u_idx] <= bus.upd_target_i;
                typ_q[u_idx] <= bus.upd_br_type_i;
            end
            if (u_alloc)
                cnt_q[u_idx] <= 2'b10;
            else if (u_train)
                cnt_q[u_idx] <= cnt_d;
        end
    end

    // RAS push on resolved CALL (overwrites oldest when full), pop on RETURN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (bus.upd_bht_update_i) begin
            if (bus.upd_br_type_i == BR_CALL) begin
                ras_q[ras_sp_q] <= bus.upd_pc_i + 30'd1;
                ras_sp_q        <= ras_sp_q + 1'b1;
                if (ras_cnt_q != (RP+1)'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + 1'b1;
            end else if (bus.upd_br_type_i == BR_RETURN && !ras_empty) begin
                ras_sp_q  <= ras_sp_q - 1'b1;
                ras_cnt_q <= ras_cnt_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bpu_predictor.sv
// Scoreboarded bench for bpu_predictor: directed scenarios plus random traffic
// against a behavioural model (full-PC match BTB, queue-based RAS).
module tb_bpu_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpu_predictor_if bus();

    bpu_predictor #(.BTB_ENTRIES(64), .RAS_DEPTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit        v;
        bit [29:0] pc;
        bit [29:0] tgt;
        bit [1:0]  typ;
        int        cnt;
    } ent_t;

    typedef struct {
        int        cyc;
        bit [29:0] npc;
        bit        tk;
    } exp_t;

    ent_t      btb [64];
    bit [29:0] ras [$];
    exp_t      sb  [$];
    int        cyc = 0;
    int        vectors = 0;
    int        miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        foreach (btb[i]) begin
            btb[i].v = 1'b0; btb[i].pc = '0; btb[i].tgt = '0;
            btb[i].typ = '0; btb[i].cnt = 1;
        end
        ras.delete();
    endfunction

    function automatic void predict(input bit [29:0] pc, output bit [29:0] npc, output bit tk);
        int i = int'(pc % 64);
        npc = pc + 30'd1;
        tk  = 1'b0;
        if (btb[i].v && btb[i].pc == pc) begin
            if (btb[i].typ == 2'd3) begin
                if (ras.size() > 0) begin npc = ras[$]; tk = 1'b1; end
            end else if (btb[i].typ != 2'd0 || btb[i].cnt >= 2) begin
                npc = btb[i].tgt; tk = 1'b1;
            end
        end
    endfunction

    function automatic void model_update(bit bu, bit hu, bit [29:0] pc, bit [29:0] tgt,
                                         bit tk, bit [1:0] ty);
        int i = int'(pc % 64);
        bit hit = btb[i].v && btb[i].pc == pc;
        bit [29:0] ret = pc + 30'd1;
        if (hu && hit)
            btb[i].cnt = tk ? ((btb[i].cnt + 1 > 3) ? 3 : btb[i].cnt + 1)
                            : ((btb[i].cnt - 1 < 0) ? 0 : btb[i].cnt - 1);
        if (bu && tk) begin
            if (!hit) begin
                btb[i].v = 1'b1; btb[i].pc = pc; btb[i].cnt = 2;
            end
            btb[i].tgt = tgt;
            btb[i].typ = ty;
        end
        if (hu) begin
            if (ty == 2'd2) begin
                ras.push_back(ret);
                if (ras.size() > 8) void'(ras.pop_front());
            end else if (ty == 2'd3 && ras.size() > 0) begin
                void'(ras.pop_back());
            end
        end
    endfunction

    // One cycle of stimulus, driven at the falling edge; expectation queued first
    task automatic cycle(input bit req, input bit [29:0] pc, input bit fl, input bit bu,
                         input bit hu, input bit [29:0] up, input bit [29:0] ut,
                         input bit tk, input bit [1:0] ty);
        bit [29:0] enpc;
        bit        etk;
        @(negedge clk);
        bus.req_i = req; bus.pc_i = pc; bus.upd_flush_i = fl;
        bus.upd_btb_update_i = bu; bus.upd_bht_update_i = hu; bus.upd_pc_i = up;
        bus.upd_target_i = ut; bus.upd_taken_i = tk; bus.upd_br_type_i = ty;
        if (req && !fl) begin
            predict(pc, enpc, etk);
            sb.push_back('{cyc + 1, enpc, etk});
        end
        model_update(bu, hu, up, ut, tk, ty);
    endtask

    task automatic upd(input bit bu, input bit hu, input bit [29:0] up, input bit [29:0] ut,
                       input bit tk, input bit [1:0] ty);
        cycle(1'b0, '0, 1'b0, bu, hu, up, ut, tk, ty);
    endtask

    task automatic look_exp(input bit [29:0] pc, input bit [29:0] enpc, input bit etk, input string nm);
        cycle(1'b1, pc, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
        @(posedge clk); #2;
        chk({nm, "_valid"}, bus.pred_valid_o, 1'b1);
        chk({nm, "_npc"}, bus.npc_o, enpc);
        chk({nm, "_taken"}, bus.pred_taken_o, etk);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                if (bus.pred_valid_o === 1'b1) begin
                    if (sb.size() == 0) chk("spurious_valid", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("sb_cycle", cyc, e.cyc);
                        chk("sb_npc", bus.npc_o, e.npc);
                        chk("sb_taken", bus.pred_taken_o, e.tk);
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    chk("sb_missing_valid", bus.pred_valid_o, 1'b1);
                end
            end
        end
    end

    initial begin
        bus.req_i = 0; bus.pc_i = '0; bus.upd_flush_i = 0; bus.upd_btb_update_i = 0;
        bus.upd_bht_update_i = 0; bus.upd_pc_i = '0; bus.upd_target_i = '0;
        bus.upd_taken_i = 0; bus.upd_br_type_i = '0;
        model_reset();
        #12;
        chk("rst_valid", bus.pred_valid_o, 1'b0);
        chk("rst_npc", bus.npc_o, 30'd0);
        chk("rst_taken", bus.pred_taken_o, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // cold lookup misses
        look_exp(30'h0700_0000, 30'h0700_0001, 1'b0, "cold");

        // PC_RELATIVE allocate, then train down to not-taken
        upd(1, 1, 30'h0700_0004, 30'h0700_0040, 1, 2'd0);
        look_exp(30'h0700_0004, 30'h0700_0040, 1'b1, "pcrel_alloc");
        upd(0, 1, 30'h0700_0004, 30'h0, 0, 2'd0);
        upd(0, 1, 30'h0700_0004, 30'h0, 0, 2'd0);
        look_exp(30'h0700_0004, 30'h0700_0005, 1'b0, "pcrel_trained");

        // aliasing at the same index evicts the older entry
        upd(1, 0, 30'h0700_0044, 30'h0700_0400, 1, 2'd0);
        look_exp(30'h0700_0004, 30'h0700_0005, 1'b0, "alias_evicted");
        look_exp(30'h0700_0044, 30'h0700_0400, 1'b1, "alias_new");

        // return prediction from the RAS; empty RAS falls back to pc+1
        upd(0, 1, 30'h0700_0008, 30'h0, 1, 2'd2);
        upd(1, 0, 30'h0700_0080, 30'h0700_0300, 1, 2'd3);
        look_exp(30'h0700_0080, 30'h0700_0009, 1'b1, "ret_ras");
        upd(0, 1, 30'h0700_0080, 30'h0700_0300, 1, 2'd3);
        look_exp(30'h0700_0080, 30'h0700_0081, 1'b0, "ret_empty");

        // nine calls into an eight-deep stack; the oldest is lost
        for (int k = 0; k < 9; k++) upd(0, 1, 30'h0700_0000 + 30'(k), 30'h0, 1, 2'd2);
        for (int j = 0; j < 8; j++) begin
            look_exp(30'h0700_0080, 30'h0700_0009 - 30'(j), 1'b1, "ras_pop");
            upd(0, 1, 30'h0700_0080, 30'h0, 1, 2'd3);
        end
        look_exp(30'h0700_0080, 30'h0700_0081, 1'b0, "ras_drained");

        // same-cycle update and lookup sees the old entry
        cycle(1, 30'h0700_0044, 0, 1, 0, 30'h0700_0044, 30'h0700_0500, 1, 2'd1);
        @(posedge clk); #2;
        chk("rbw_npc", bus.npc_o, 30'h0700_0400);
        look_exp(30'h0700_0044, 30'h0700_0500, 1'b1, "rbw_after");

        // flush kills the in-flight prediction
        cycle(1, 30'h0700_0044, 1, 0, 0, '0, '0, 0, 2'd0);
        @(posedge clk); #2;
        chk("flush_valid", bus.pred_valid_o, 1'b0);

        // asynchronous reset mid-stream
        cycle(1, 30'h0700_0044, 0, 0, 0, '0, '0, 0, 2'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.pred_valid_o, 1'b0);
        chk("arst_npc", bus.npc_o, 30'd0);
        chk("arst_taken", bus.pred_taken_o, 1'b0);
        sb.delete();
        model_reset();
        bus.req_i = 0; bus.upd_btb_update_i = 0; bus.upd_bht_update_i = 0; bus.upd_flush_i = 0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        look_exp(30'h0700_0044, 30'h0700_0045, 1'b0, "post_rst_a");
        look_exp(30'h0700_0004, 30'h0700_0005, 1'b0, "post_rst_b");

        // random traffic over a small aliasing PC pool
        for (int n = 0; n < 1500; n++) begin
            bit [29:0] lp = 30'h0700_0000 + 30'($urandom_range(0, 5)) + 30'(64 * $urandom_range(0, 1));
            bit [29:0] up = 30'h0700_0000 + 30'($urandom_range(0, 5)) + 30'(64 * $urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, lp, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) < 2, $urandom_range(0, 1) == 1, up,
                  30'($urandom), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
        end

        for (int n = 0; n < 3; n++) upd(0, 0, '0, '0, 0, 2'd0);
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
